// File: rtl/servo_ramp_scheduler.sv
// Frame-synchronous duty ramp scheduler: steps each channel's duty toward its
// target once per PWM frame and emits per-channel latch pulses at frame end.
`timescale 1ns/1ps
module servo_ramp_scheduler #(
    parameter int NCH    = 4,
    parameter int DUTY_W = 8,
    parameter int STEP_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     wr_en,
    input  logic [$clog2(NCH)-1:0]   wr_ch,
    input  logic [DUTY_W-1:0]        wr_target,
    input  logic [STEP_W-1:0]        wr_step,
    output logic [NCH*DUTY_W-1:0]    duty_out,
    output logic [NCH-1:0]           latch_out,
    output logic [NCH-1:0]           at_target,
    output logic                     busy,
    output logic                     overrun
);
    localparam int CH_W  = $clog2(NCH);
    localparam int EXT_W = DUTY_W + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);
    localparam logic [CH_W-1:0] ONE_CH  = CH_W'(1);
    localparam logic [NCH-1:0]  ONE_MASK = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CH_W-1:0]   ch_idx_r, ch_idx_s;
    logic [DUTY_W-1:0] target_r  [NCH];
    logic [STEP_W-1:0] step_r    [NCH];
    logic [DUTY_W-1:0] current_r [NCH];
    logic [NCH-1:0]    changed_r, changed_s;
    logic [NCH-1:0]    latch_r, latch_s;
    logic [NCH-1:0]    at_target_r;
    logic              busy_r;
    logic              overrun_r;
    logic              scan_s;
    logic [DUTY_W-1:0] ramp_s;

    // Extended-width arithmetic keeps current+step and target+step from wrapping.
    function automatic logic [DUTY_W-1:0] ramp_next(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [STEP_W-1:0] stp
    );
        logic [EXT_W-1:0]  cur_e;
        logic [EXT_W-1:0]  tgt_e;
        logic [EXT_W-1:0]  stp_e;
        logic [EXT_W-1:0]  sum_e;
        logic [EXT_W-1:0]  dif_e;
        logic [DUTY_W-1:0] res;
        cur_e = {1'b0, cur};
        tgt_e = {1'b0, tgt};
        stp_e = {{(EXT_W-STEP_W){1'b0}}, stp};
        sum_e = cur_e + stp_e;
        dif_e = cur_e - stp_e;
        if (stp == {STEP_W{1'b0}}) begin
            res = tgt;
        end else if (cur_e < tgt_e) begin
            res = (sum_e >= tgt_e) ? tgt : sum_e[DUTY_W-1:0];
        end else if (cur_e > tgt_e) begin
            res = (cur_e <= (tgt_e + stp_e)) ? tgt : dif_e[DUTY_W-1:0];
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Next-state, scan index, changed-mask and latch pulse decode.
    always_comb begin
        state_s   = state_r;
        ch_idx_s  = ch_idx_r;
        changed_s = changed_r;
        latch_s   = {NCH{1'b0}};
        scan_s    = 1'b0;
        ramp_s    = ramp_next(current_r[ch_idx_r], target_r[ch_idx_r], step_r[ch_idx_r]);
        case (state_r)
            ST_IDLE: begin
                if (frame_tick) begin
                    state_s  = ST_SCAN;
                    ch_idx_s = {CH_W{1'b0}};
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SCAN: begin
                scan_s = 1'b1;
                if (ramp_s != current_r[ch_idx_r]) begin
                    changed_s = changed_r | (ONE_MASK << ch_idx_r);
                end else begin
                    changed_s = changed_r;
                end
                if (ch_idx_r == LAST_CH) begin
                    state_s  = ST_LATCH;
                    ch_idx_s = {CH_W{1'b0}};
                    latch_s  = changed_s;
                end else begin
                    ch_idx_s = ch_idx_r + ONE_CH;
                end
            end
            ST_LATCH: begin
                state_s   = ST_IDLE;
                changed_s = {NCH{1'b0}};
            end
            default: begin
                state_s   = ST_IDLE;
                ch_idx_s  = {CH_W{1'b0}};
                changed_s = {NCH{1'b0}};
            end
        endcase
    end

    // Control state, status flags and latch pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ch_idx_r  <= {CH_W{1'b0}};
            changed_r <= {NCH{1'b0}};
            latch_r   <= {NCH{1'b0}};
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ch_idx_r  <= ch_idx_s;
            changed_r <= changed_s;
            latch_r   <= latch_s;
            busy_r    <= (state_s != ST_IDLE);
            overrun_r <= overrun_r | (frame_tick & (state_r != ST_IDLE));
        end
    end

    // Per-channel configuration, duty ramp and at-target flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                target_r[i]  <= {DUTY_W{1'b0}};
                step_r[i]    <= {STEP_W{1'b0}};
                current_r[i] <= {DUTY_W{1'b0}};
            end
            at_target_r <= {NCH{1'b1}};
        end else begin
            if (wr_en) begin
                target_r[wr_ch] <= wr_target;
                step_r[wr_ch]   <= wr_step;
            end
            // The scan reads the registered target/step, so a same-cycle write waits a frame.
            if (scan_s) begin
                current_r[ch_idx_r] <= ramp_s;
            end
            for (int i = 0; i < NCH; i++) begin
                at_target_r[i] <= (current_r[i] == target_r[i]);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_duty
        assign duty_out[DUTY_W*g +: DUTY_W] = current_r[g];
    end

    assign latch_out = latch_r;
    assign at_target = at_target_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Self-checking bench for servo_ramp_scheduler: table of write/frame records
// checked through a per-frame scoreboard, plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_servo_ramp_scheduler;
    localparam int NCH    = 4;
    localparam int DUTY_W = 8;
    localparam int STEP_W = 4;
    localparam int CH_W   = 2;
    localparam int NVEC   = 10;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  frame_tick;
    logic                  wr_en;
    logic [CH_W-1:0]       wr_ch;
    logic [DUTY_W-1:0]     wr_target;
    logic [STEP_W-1:0]     wr_step;
    logic [NCH*DUTY_W-1:0] duty_out;
    logic [NCH-1:0]        latch_out;
    logic [NCH-1:0]        at_target;
    logic                  busy;
    logic                  overrun;

    always #5 clock = ~clock;

    servo_ramp_scheduler #(.NCH(NCH), .DUTY_W(DUTY_W), .STEP_W(STEP_W)) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_target(wr_target), .wr_step(wr_step),
        .duty_out(duty_out), .latch_out(latch_out), .at_target(at_target),
        .busy(busy), .overrun(overrun)
    );

    typedef struct {
        logic [NCH*DUTY_W-1:0] duty;
        logic [NCH-1:0]        latch;
    } sb_t;

    typedef struct {
        int ch;
        int tgt;
        int stp;
        int frames;
        int exp_duty;
        bit exp_at;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[NVEC];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cur[NCH];
    int   m_tgt[NCH];
    int   m_stp[NCH];
    logic [NCH-1:0] last_latch;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ramp(input int c, input int t, input int s);
        if (s == 0) return t;
        if (c < t) return (c + s > t) ? t : c + s;
        if (c > t) return (c - s < t) ? t : c - s;
        return c;
    endfunction

    function automatic logic [NCH*DUTY_W-1:0] pack_duty();
        logic [NCH*DUTY_W-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*DUTY_W +: DUTY_W] = DUTY_W'(m_cur[i]);
        return r;
    endfunction

    function automatic logic [NCH-1:0] at_mask();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (m_cur[i] == m_tgt[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cur[i] = 0;
            m_tgt[i] = 0;
            m_stp[i] = 0;
        end
    endtask

    // Called just after a negedge; at_target must switch exactly two cycles after the write.
    task automatic do_write(input int ch, input int tgt, input int stp);
        logic [NCH-1:0] old_at;
        old_at    = at_mask();
        wr_en     = 1'b1;
        wr_ch     = CH_W'(ch);
        wr_target = DUTY_W'(tgt);
        wr_step   = STEP_W'(stp);
        m_tgt[ch] = tgt;
        m_stp[ch] = stp;
        @(negedge clock);
        wr_en = 1'b0;
        chk("at_target_write_plus1", at_target, old_at);
        @(negedge clock);
        chk("at_target_write_plus2", at_target, at_mask());
    endtask

    // One frame: tick now, optional tick or write in cycle t+ev_cyc, checks to t+NCH+2.
    task automatic run_frame(input string name, input int ev_cyc, input bit ev_tick,
                             input int ev_ch, input int ev_tgt, input int ev_stp);
        sb_t e;
        sb_t got;
        int  busy_cnt;
        e.latch = '0;
        for (int c = 0; c < NCH; c++) begin
            int n;
            n = ramp(m_cur[c], m_tgt[c], m_stp[c]);
            if (n != m_cur[c]) e.latch[c] = 1'b1;
            m_cur[c] = n;
        end
        e.duty = pack_duty();
        sb_q.push_back(e);
        if (ev_cyc > 0 && !ev_tick) begin
            m_tgt[ev_ch] = ev_tgt;
            m_stp[ev_ch] = ev_stp;
        end
        frame_tick = 1'b1;
        busy_cnt   = 0;
        for (int i = 1; i <= NCH + 2; i++) begin
            @(negedge clock);
            if (busy) busy_cnt++;
            if (i == NCH + 1) begin
                if (sb_q.size() == 0) begin
                    chk({name, "_scoreboard_empty"}, 64'd1, 64'd0);
                end else begin
                    got = sb_q.pop_front();
                    chk({name, "_latch"}, latch_out, got.latch);
                    chk({name, "_duty"}, duty_out, got.duty);
                    last_latch = latch_out;
                end
            end else begin
                chk({name, "_latch_quiet"}, latch_out, '0);
            end
            if (i == NCH + 2) begin
                chk({name, "_busy_end"}, busy, 1'b0);
                chk({name, "_busy_cycles"}, busy_cnt, NCH + 1);
                chk({name, "_at_target"}, at_target, at_mask());
            end
            if (ev_cyc > 0 && ev_tick && i == ev_cyc + 1) chk({name, "_overrun_set"}, overrun, 1'b1);
            if (i == 1) frame_tick = 1'b0;
            if (ev_cyc > 0 && i == ev_cyc + 1) begin
                frame_tick = 1'b0;
                wr_en      = 1'b0;
            end
            if (ev_cyc > 0 && i == ev_cyc) begin
                if (ev_tick) begin
                    frame_tick = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    wr_ch     = CH_W'(ev_ch);
                    wr_target = DUTY_W'(ev_tgt);
                    wr_step   = STEP_W'(ev_stp);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; wr_en = 1'b0;
        wr_ch = '0; wr_target = '0; wr_step = '0;
        last_latch = '0;
        model_reset();
        //           ch  tgt step frames exp  at
        vecs[0] = '{1, 100, 8, 13, 100, 1'b1};
        vecs[1] = '{1, 100, 8,  1, 100, 1'b1};
        vecs[2] = '{2, 250, 0,  1, 250, 1'b1};
        vecs[3] = '{2,   3, 15, 17,  3, 1'b1};
        vecs[4] = '{0,  17, 5,  4,  17, 1'b1};
        vecs[5] = '{0,   0, 7,  3,   0, 1'b1};
        vecs[6] = '{3, 255, 15, 17, 255, 1'b1};
        vecs[7] = '{1,   0, 15, 7,   0, 1'b1};
        vecs[8] = '{1,  50, 5,  3,  15, 1'b0};
        vecs[9] = '{1,  15, 5,  1,  15, 1'b1};

        repeat (3) @(negedge clock);
        chk("reset_duty", duty_out, '0);
        chk("reset_latch", latch_out, '0);
        chk("reset_at_target", at_target, 4'b1111);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        reset = 1'b0;
        run_frame("idle_frame", 0, 1'b0, 0, 0, 0);
        chk("idle_duty", duty_out, '0);

        for (int v = 0; v < NVEC; v++) begin
            do_write(vecs[v].ch, vecs[v].tgt, vecs[v].stp);
            for (int f = 0; f < vecs[v].frames; f++) begin
                run_frame("vec_frame", 0, 1'b0, 0, 0, 0);
                if (v == 0) chk("ramp_up_value", duty_out[DUTY_W +: DUTY_W], ((f + 1) * 8 > 100) ? 100 : (f + 1) * 8);
            end
            chk("vec_duty", duty_out[vecs[v].ch*DUTY_W +: DUTY_W], vecs[v].exp_duty);
            chk("vec_at_target", at_target[vecs[v].ch], vecs[v].exp_at);
        end
        chk("no_latch_14th_tick_seen", vecs[1].frames, 1);

        // Same-cycle write to ch3 while it is scanned: this frame still uses target 0 / step 15.
        do_write(0, 20, 4);
        do_write(3, 0, 15);
        run_frame("simul", NCH, 1'b0, 3, 250, 1);
        chk("simul_latch_mask", last_latch, 4'b1001);
        chk("simul_ch3_old", duty_out[3*DUTY_W +: DUTY_W], 240);
        chk("simul_ch0", duty_out[0 +: DUTY_W], 4);
        run_frame("simul_next", 0, 1'b0, 0, 0, 0);
        chk("simul_ch3_new", duty_out[3*DUTY_W +: DUTY_W], 241);
        chk("simul_ch0_next", duty_out[0 +: DUTY_W], 8);

        chk("overrun_clear_before", overrun, 1'b0);
        run_frame("overrun", 2, 1'b1, 0, 0, 0);
        chk("overrun_held", overrun, 1'b1);
        run_frame("after_overrun", 0, 1'b0, 0, 0, 0);
        chk("overrun_sticky", overrun, 1'b1);
        chk("after_overrun_ch3", duty_out[3*DUTY_W +: DUTY_W], 243);

        // Reset asserted in cycle t+2 of a scan.
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midscan_duty", duty_out, '0);
        chk("midscan_latch", latch_out, '0);
        chk("midscan_busy", busy, 1'b0);
        chk("midscan_at_target", at_target, 4'b1111);
        chk("midscan_overrun", overrun, 1'b0);
        model_reset();
        sb_q.delete();
        for (int i = 0; i < NCH + 3; i++) begin
            @(negedge clock);
            chk("midscan_no_latch", latch_out, '0);
            chk("midscan_idle", busy, 1'b0);
        end
        do_write(2, 9, 0);
        run_frame("post_reset", 0, 1'b0, 0, 0, 0);
        chk("post_reset_latch", last_latch, 4'b0100);
        chk("post_reset_ch2", duty_out[2*DUTY_W +: DUTY_W], 9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
